ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries the per-instruction control word produced by the ID-stage decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers of the RV32I core. Detects load-use hazards and drives pipeline stall, bubble insertion and branch flush. Also generates the EX-stage forwarding selects. It sits between the decoder and the EX/MEM/WB datapath, and is the consuming end of the decoder's control interface.

## Interface
- No parameters. Register index width is fixed at 5. Fetch/decode is 1-wide.
- clk  in  1  core clock. One clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula, id_branch  in  1 each  decoder outputs for the instruction in ID.
- id_ula_op  in  2  decoder ULA operation select.
- id_rs1, id_rs2, id_rd  in  5 each  register fields of the instruction in ID.
- ex_taken  in  1  branch or jump in EX resolved taken this cycle.
- stall  out  1  hold PC and IF/ID this cycle. Combinational.
- flush  out  1  kill IF/ID contents this cycle. Combinational.
- ex_mux_ula, ex_branch  out  1 each  ID/EX register.
- ex_ula_op  out  2  ID/EX register.
- ex_rs1, ex_rs2, ex_rd  out  5 each  ID/EX register.
- mem_mem_rd, mem_mem_wr, mem_reg_wr  out  1 each  EX/MEM register.
- mem_rd_idx  out  5  EX/MEM register.
- wb_reg_wr, wb_mux_reg_wr  out  1 each  MEM/WB register.
- wb_rd  out  5  MEM/WB register.
- fwd_a, fwd_b  out  2 each  EX operand source selects. Combinational.

## Operation
- **Capture rule.** A B-type instruction is identified by branch=1 and mux_reg_wr=0. Its reg_wr is forced to 0 on capture into ID/EX. JAL (branch=1, mux_reg_wr=1) keeps reg_wr.
- **Load identification.** A load in EX is ex mem_rd=1 and mem_wr=0. Stores set both, so they are not loads.
- **Load-use stall.** stall = EX holds a load, ex_reg_wr=1, ex_rd≠0, and (ex_rd==id_rs1 or ex_rd==id_rs2). Both source fields are always compared. Spurious stalls on unused rs fields are accepted.
- **Flush.** flush = ex_taken. When ex_taken=1, stall is forced to 0 so the PC loads the target.
- **ID/EX update.** A bubble (all control and index bits 0) is loaded when rst, ex_taken or stall is high. Otherwise ID/EX loads the ID inputs.
- **EX/MEM and MEM/WB.** These always advance: EX/MEM←ID/EX, MEM/WB←EX/MEM. They are zeroed on rst. The taken branch or jump in EX still advances, so JAL writes rd.
- **fwd_a.**
  - FWD_MEM (2'b10) if mem_reg_wr, mem_rd_idx≠0 and mem_rd_idx==ex_rs1.
  - Else FWD_WB (2'b01) if wb_reg_wr, wb_rd≠0 and wb_rd==ex_rs1.
  - Else FWD_NONE (2'b00).
- **fwd_b.** Same rules as fwd_a, using ex_rs2.
- **Priority.** MEM beats WB. rst beats everything. ex_taken beats stall.

## Timing
- **Reset.** All registered outputs are 0 in the cycle after rst is sampled high. With zeroed registers, stall=0 and fwd_a/fwd_b=00; flush follows ex_taken. Reset mid-stream discards all in-flight control words.
- **Latency.** ID inputs appear on ex_* 1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later.
- **Stall.** Lasts exactly 1 cycle per load-use pair, because the load leaves EX and the bubble fills it.
- **Forwarding after a stall.** The dependent instruction then reaches EX with the load in WB, giving fwd=01.
- **Simultaneous stall and ex_taken.** One bubble is inserted, stall=0 and flush=1.
- **Back-to-back taken branches.** Each produces flush for 1 cycle.

## Structure
- Package ctrl_pkg holds:
  - the FWD_NONE/FWD_WB/FWD_MEM constants;
  - the packed control-word type (mem_rd, mem_wr, reg_wr, mux_reg_wr, mux_ula, ula_op, branch, rd, rs1, rs2);
  - the BUBBLE constant.
- One combinational sub-module, hazard_unit, computes stall, flush, fwd_a and fwd_b. The pipeline registers stay in ctrl_pipe.

## Test plan
- **Reset.** Drive rst high for 2 cycles with random ID inputs → all ex_/mem_/wb_ outputs 0, stall=0, fwd=00.
- **Load-use.** Load rd=5 in ID, then add rs1=5 → stall=1 for exactly 1 cycle and ex_* goes to bubble. The add then reaches EX with fwd_a=01 while wb_rd=5.
- **EX/MEM forward.** add rd=7, then sub rs2=7 → fwd_b=10 when sub is in EX. With rd=0 instead, fwd_b=00.
- **Forward priority.** Two writers to x3 back-to-back, then a reader of x3 → fwd_a=10 (MEM wins over WB).
- **Branch flush.** Taken B-type in EX with ex_taken=1 while a load-use condition is also present → flush=1, stall=0, next ex_* is bubble. The branch carries mem_reg_wr=0.
- **JAL write-back.** JAL rd=1 taken → wb_reg_wr=1 and wb_mux_reg_wr=1 with wb_rd=1 three cycles after ID.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-word types, forwarding selects and helpers for ctrl_pipe
package ctrl_pkg;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mux_reg_wr;
    logic       mux_ula;
    logic [1:0] ula_op;
    logic       branch;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;
  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mux_reg_wr;
    logic [4:0] rd;
  } mem_t;
  typedef struct packed {
    logic       reg_wr;
    logic       mux_reg_wr;
    logic [4:0] rd;
  } wb_t;
  localparam ctrl_t BUBBLE = '0;
  function automatic logic [1:0] fwd_sel(input logic m_wr, input logic [4:0] m_rd,
                                         input logic w_wr, input logic [4:0] w_rd,
                                         input logic [4:0] rs);
    return (m_wr && m_rd != 5'd0 && m_rd == rs) ? FWD_MEM :
           (w_wr && w_rd != 5'd0 && w_rd == rs) ? FWD_WB : FWD_NONE;
  endfunction
endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: load-use stall, branch flush and EX forwarding selects
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic       ex_taken,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_mem_rd,
  input  logic       ex_mem_wr,
  input  logic       ex_reg_wr,
  input  logic [4:0] ex_rd,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       mem_reg_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_wr,
  input  logic [4:0] wb_rd,
  output logic       stall,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  // a taken branch overrides the load-use stall so the PC can load the target
  always_comb begin
    flush = ex_taken;
    stall = !ex_taken && ex_mem_rd && !ex_mem_wr && ex_reg_wr && ex_rd != 5'd0 &&
            (ex_rd == id_rs1 || ex_rd == id_rs2);
    fwd_a = fwd_sel(mem_reg_wr, mem_rd, wb_reg_wr, wb_rd, ex_rs1);
    fwd_b = fwd_sel(mem_reg_wr, mem_rd, wb_reg_wr, wb_rd, ex_rs2);
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control registers with hazard handling
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_mem_rd,
  input  logic       id_mem_wr,
  input  logic       id_reg_wr,
  input  logic       id_mux_reg_wr,
  input  logic       id_mux_ula,
  input  logic       id_branch,
  input  logic [1:0] id_ula_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       ex_taken,
  output logic       stall,
  output logic       flush,
  output logic       ex_mux_ula,
  output logic       ex_branch,
  output logic [1:0] ex_ula_op,
  output logic [4:0] ex_rs1,
  output logic [4:0] ex_rs2,
  output logic [4:0] ex_rd,
  output logic       mem_mem_rd,
  output logic       mem_mem_wr,
  output logic       mem_reg_wr,
  output logic [4:0] mem_rd_idx,
  output logic       wb_reg_wr,
  output logic       wb_mux_reg_wr,
  output logic [4:0] wb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  ctrl_t id_c, ex_d, ex_q;
  mem_t  mem_c, mem_d, mem_q;
  wb_t   wb_c, wb_d, wb_q;
  // B-type (branch without rd write-back mux) never writes a register; bubbles on rst/flush/stall
  always_comb begin
    id_c  = '{mem_rd: id_mem_rd, mem_wr: id_mem_wr,
              reg_wr: id_reg_wr & ~(id_branch & ~id_mux_reg_wr),
              mux_reg_wr: id_mux_reg_wr, mux_ula: id_mux_ula, ula_op: id_ula_op,
              branch: id_branch, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
    mem_c = '{mem_rd: ex_q.mem_rd, mem_wr: ex_q.mem_wr, reg_wr: ex_q.reg_wr,
              mux_reg_wr: ex_q.mux_reg_wr, rd: ex_q.rd};
    wb_c  = '{reg_wr: mem_q.reg_wr, mux_reg_wr: mem_q.mux_reg_wr, rd: mem_q.rd};
    ex_d  = (rst || flush || stall) ? BUBBLE : id_c;
    mem_d = rst ? '0 : mem_c;
    wb_d  = rst ? '0 : wb_c;
  end
  // pipeline registers advance every cycle
  always_ff @(posedge clk) begin
    ex_q  <= ex_d;
    mem_q <= mem_d;
    wb_q  <= wb_d;
  end
  assign ex_mux_ula    = ex_q.mux_ula;
  assign ex_branch     = ex_q.branch;
  assign ex_ula_op     = ex_q.ula_op;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign mem_mem_rd    = mem_q.mem_rd;
  assign mem_mem_wr    = mem_q.mem_wr;
  assign mem_reg_wr    = mem_q.reg_wr;
  assign mem_rd_idx    = mem_q.rd;
  assign wb_reg_wr     = wb_q.reg_wr;
  assign wb_mux_reg_wr = wb_q.mux_reg_wr;
  assign wb_rd         = wb_q.rd;
  hazard_unit u_hazard (
    .ex_taken  (ex_taken),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_mem_rd (ex_q.mem_rd),
    .ex_mem_wr (ex_q.mem_wr),
    .ex_reg_wr (ex_q.reg_wr),
    .ex_rd     (ex_q.rd),
    .ex_rs1    (ex_q.rs1),
    .ex_rs2    (ex_q.rs2),
    .mem_reg_wr(mem_q.reg_wr),
    .mem_rd    (mem_q.rd),
    .wb_reg_wr (wb_q.reg_wr),
    .wb_rd     (wb_q.rd),
    .stall     (stall),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe
module tb_ctrl_pipe;
  logic       clk = 1'b0, rst = 1'b1;
  logic       id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula, id_branch;
  logic [1:0] id_ula_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_taken = 1'b0;
  logic       stall, flush, ex_mux_ula, ex_branch;
  logic [1:0] ex_ula_op, fwd_a, fwd_b;
  logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd_idx, wb_rd;
  logic       mem_mem_rd, mem_mem_wr, mem_reg_wr, wb_reg_wr, wb_mux_reg_wr;
  int checks = 0, failures = 0;
  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr),
    .id_mux_reg_wr(id_mux_reg_wr), .id_mux_ula(id_mux_ula), .id_branch(id_branch),
    .id_ula_op(id_ula_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_taken(ex_taken), .stall(stall), .flush(flush),
    .ex_mux_ula(ex_mux_ula), .ex_branch(ex_branch), .ex_ula_op(ex_ula_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_reg_wr(mem_reg_wr),
    .mem_rd_idx(mem_rd_idx), .wb_reg_wr(wb_reg_wr), .wb_mux_reg_wr(wb_mux_reg_wr),
    .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic id(input logic mr, mw, rw, mrw, mu, input logic [1:0] op, input logic br,
                    input logic [4:0] r1, r2, d);
    {id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_mux_ula, id_ula_op, id_branch} =
      {mr, mw, rw, mrw, mu, op, br};
    {id_rs1, id_rs2, id_rd} = {r1, r2, d};
    #1;
  endtask
  task automatic nop();
    id(0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 5'd0, 5'd0);
  endtask
  function automatic logic [31:0] ex_all();
    return {13'd0, ex_mux_ula, ex_branch, ex_ula_op, ex_rs1, ex_rs2, ex_rd};
  endfunction
  function automatic logic [31:0] mw_all();
    return {17'd0, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_rd_idx, wb_reg_wr, wb_mux_reg_wr, wb_rd};
  endfunction
  initial begin
    // reset with random ID inputs
    id($urandom, $urandom, $urandom, $urandom, $urandom, 2'($urandom), $urandom,
       5'($urandom), 5'($urandom), 5'($urandom));
    tick();
    id($urandom, $urandom, $urandom, $urandom, $urandom, 2'($urandom), $urandom,
       5'($urandom), 5'($urandom), 5'($urandom));
    tick();
    chk("rst_ex", ex_all(), 32'd0);
    chk("rst_mem_wb", mw_all(), 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    rst = 1'b0;
    // load-use: load x5, then add reads x5
    id(1, 0, 1, 1, 1, 2'd0, 0, 5'd2, 5'd0, 5'd5);
    tick();
    chk("ld_ex_rd", {27'd0, ex_rd}, 32'd5);
    id(0, 0, 1, 0, 0, 2'd2, 0, 5'd5, 5'd6, 5'd8);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_flush", {31'd0, flush}, 32'd0);
    tick();
    chk("lu_bubble", ex_all(), 32'd0);
    chk("lu_stall_end", {31'd0, stall}, 32'd0);
    chk("lu_mem_rd", {27'd0, mem_rd_idx}, 32'd5);
    tick();
    chk("lu_ex_rs1", {27'd0, ex_rs1}, 32'd5);
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("lu_wb", {26'd0, wb_reg_wr, wb_rd}, {26'd0, 1'b1, 5'd5});
    // EX/MEM forward to rs2
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd1, 5'd1, 5'd7);
    tick();
    id(0, 0, 1, 0, 0, 2'd1, 0, 5'd1, 5'd7, 5'd9);
    tick();
    chk("fwdmem_b", {30'd0, fwd_b}, 32'd2);
    chk("fwdmem_a", {30'd0, fwd_a}, 32'd0);
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd1, 5'd1, 5'd0);
    tick();
    id(0, 0, 1, 0, 0, 2'd1, 0, 5'd1, 5'd0, 5'd9);
    tick();
    chk("fwd_x0_b", {30'd0, fwd_b}, 32'd0);
    // MEM beats WB for x3
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd1, 5'd2, 5'd3);
    tick();
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd3, 5'd4, 5'd3);
    tick();
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd3, 5'd3, 5'd10);
    tick();
    chk("prio_a", {30'd0, fwd_a}, 32'd2);
    chk("prio_b", {30'd0, fwd_b}, 32'd2);
    nop();
    tick();
    tick();
    chk("wb_only_a", {30'd0, fwd_a}, 32'd0);
    // taken branch while a load-use condition is present
    id(1, 0, 1, 1, 1, 2'd0, 0, 5'd1, 5'd0, 5'd4);
    tick();
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd4, 5'd0, 5'd11);
    chk("pre_taken_stall", {31'd0, stall}, 32'd1);
    ex_taken = 1'b1;
    #1;
    chk("taken_stall", {31'd0, stall}, 32'd0);
    chk("taken_flush", {31'd0, flush}, 32'd1);
    tick();
    ex_taken = 1'b0;
    #1;
    chk("taken_bubble", ex_all(), 32'd0);
    chk("taken_flush_off", {31'd0, flush}, 32'd0);
    chk("taken_ld_mem", {26'd0, mem_mem_rd, mem_rd_idx}, {26'd0, 1'b1, 5'd4});
    // B-type capture drops reg_wr
    id(0, 0, 1, 0, 0, 2'd1, 1, 5'd1, 5'd2, 5'd6);
    tick();
    chk("br_ex", {30'd0, ex_branch, ex_mux_ula}, 32'd2);
    nop();
    ex_taken = 1'b1;
    #1;
    chk("br_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("br_back2back_flush", {31'd0, flush}, 32'd1);
    ex_taken = 1'b0;
    #1;
    chk("br_bubble", ex_all(), 32'd0);
    chk("br_mem", {26'd0, mem_reg_wr, mem_rd_idx}, {26'd0, 1'b0, 5'd6});
    // JAL keeps reg_wr and writes rd three cycles after ID
    id(0, 0, 1, 1, 0, 2'd0, 1, 5'd0, 5'd0, 5'd1);
    tick();
    id(0, 0, 1, 0, 0, 2'd0, 0, 5'd7, 5'd8, 5'd9);
    ex_taken = 1'b1;
    tick();
    ex_taken = 1'b0;
    nop();
    chk("jal_bubble", ex_all(), 32'd0);
    tick();
    chk("jal_wb", {25'd0, wb_reg_wr, wb_mux_reg_wr, wb_rd}, {25'd0, 1'b1, 1'b1, 5'd1});
    // reset mid-stream discards in-flight words
    id(1, 1, 1, 1, 1, 2'd3, 0, 5'd12, 5'd13, 5'd14);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ex", ex_all(), 32'd0);
    chk("midrst_mem_wb", mw_all(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
